// File: rtl/spi_defs_pkg.sv
// spi_defs_pkg: definitions shared between the SPI slave and spi_ram_ctrl.
//   RX_WIDTH / TX_WIDTH : word widths on the slave rx and tx sides.
//   CMD_*               : two-bit command codes carried in rx_data[9:8].
//   tx_state_e          : states of the read-data hold FSM.
package spi_defs_pkg;

    localparam int unsigned RX_WIDTH = 10;
    localparam int unsigned TX_WIDTH = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        StTxIdle = 1'b0,
        StTxHold = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: MEM_DEPTH x 8-bit RAM with one synchronous write port and one
// synchronous (registered) read port. Accesses at addresses >= MEM_DEPTH are
// out of range: writes are dropped and reads return zero.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset (read register only)
//   wr_en_i/addr/data   write port
//   rd_en_i/rd_addr_i   read strobe and address; rd_data_o updates on the next edge
//   rd_data_o           registered read data, holds between reads
module spi_ram_mem
    import spi_defs_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [TX_WIDTH-1:0]  wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    output logic [TX_WIDTH-1:0]  rd_data_o
);

    logic [TX_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [TX_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                wr_in_range, rd_in_range;

    always_comb begin
        wr_in_range = 32'(wr_addr_i) < MEM_DEPTH;
        rd_in_range = 32'(rd_addr_i) < MEM_DEPTH;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_in_range ? mem_q[rd_addr_i] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents are never reset; only writes during reset are suppressed.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en_i && wr_in_range) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes 10-bit command words from the SPI slave into RAM
// address/data operations and presents read bytes to the slave for shift-out.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   din       command word: [9:8] command, [7:0] payload
//   rx_valid  din valid this cycle
//   dout      read data to the slave tx_data
//   tx_valid  dout valid, held TX_HOLD cycles per read
// Build option: define AUTO_INC_EN to post-increment wr_addr after WR_DATA and
// rd_addr after RD_DATA, wrapping MEM_DEPTH-1 -> 0.
module spi_ram_ctrl
    import spi_defs_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TX_HOLD   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RX_WIDTH-1:0] din,
    input  logic                rx_valid,
    output logic [TX_WIDTH-1:0] dout,
    output logic                tx_valid
);

    localparam int unsigned CntW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    // Counter holds the number of hold cycles still to run after the current one.
    localparam logic [CntW-1:0] HoldLast = CntW'(TX_HOLD - 1);

    tx_state_e            state_d, state_q;
    logic [CntW-1:0]      cnt_d, cnt_q;
    logic [ADDR_SIZE-1:0] wr_addr_d, wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_d, rd_addr_q;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 wr_en, rd_en;

`ifdef AUTO_INC_EN
    // Out-of-range addresses count up through the top of the address space.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    assign payload_addr = din[ADDR_SIZE-1:0];

    // Command decode and address registers.
    always_comb begin
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        if (rx_valid) begin
            unique case (din[9:8])
                CMD_WR_ADDR: wr_addr_d = payload_addr;
                CMD_WR_DATA: begin
                    wr_en = 1'b1;
`ifdef AUTO_INC_EN
                    wr_addr_d = next_addr(wr_addr_q);
`endif
                end
                CMD_RD_ADDR: rd_addr_d = payload_addr;
                CMD_RD_DATA: begin
                    rd_en = 1'b1;
`ifdef AUTO_INC_EN
                    rd_addr_d = next_addr(rd_addr_q);
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // tx FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StTxIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // tx FSM: next state. A read in either state (re)starts the full hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StTxIdle: begin
                if (rd_en) begin
                    state_d = StTxHold;
                    cnt_d   = HoldLast;
                end
            end
            StTxHold: begin
                if (rd_en) begin
                    cnt_d = HoldLast;
                end else if (cnt_q == '0) begin
                    state_d = StTxIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StTxIdle;
        endcase
    end

    // tx FSM: outputs.
    always_comb begin
        tx_valid = (state_q == StTxHold);
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (din[TX_WIDTH-1:0]),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (dout)
    );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (MEM_DEPTH 256 and 200) share one
// stimulus stream; a transaction-level model tracks each and is compared on
// every falling edge, with literal expectations at key points.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout_a, dout_b;
    logic       txv_a, txv_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(8)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout_a),
        .tx_valid (txv_a)
    );

    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .TX_HOLD(8)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout_b),
        .tx_valid (txv_b)
    );

    logic [7:0] dout_w [2];
    logic       txv_w  [2];
    assign dout_w[0] = dout_a;
    assign dout_w[1] = dout_b;
    assign txv_w[0]  = txv_a;
    assign txv_w[1]  = txv_b;

    // ---------------- model ----------------
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wa    [2] = '{0, 0};
    int         m_ra    [2] = '{0, 0};
    int         m_rem   [2] = '{0, 0};
    logic [7:0] m_dout  [2] = '{8'h00, 8'h00};
    bit         m_dk    [2] = '{1'b1, 1'b1};
`ifdef AUTO_INC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    function automatic int bump(input int a, input int depth);
        return (a == depth - 1) ? 0 : (a + 1) % 256;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_wa[i] = 0; m_ra[i] = 0; m_rem[i] = 0;
                m_dout[i] = 8'h00; m_dk[i] = 1'b1;
            end else begin
                if (m_rem[i] > 0) m_rem[i]--;
                if (rx_valid) begin
                    case (din[9:8])
                        2'd0: m_wa[i] = int'(din[7:0]);
                        2'd1: begin
                            if (m_wa[i] < depth_of(i)) begin
                                m_mem[i][m_wa[i]]   = din[7:0];
                                m_known[i][m_wa[i]] = 1'b1;
                            end
                            if (AutoInc) m_wa[i] = bump(m_wa[i], depth_of(i));
                        end
                        2'd2: m_ra[i] = int'(din[7:0]);
                        default: begin
                            if (m_ra[i] < depth_of(i)) begin
                                m_dout[i] = m_mem[i][m_ra[i]];
                                m_dk[i]   = m_known[i][m_ra[i]];
                            end else begin
                                m_dout[i] = 8'h00;
                                m_dk[i]   = 1'b1;
                            end
                            m_rem[i] = 8;
                            if (AutoInc) m_ra[i] = bump(m_ra[i], depth_of(i));
                        end
                    endcase
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_txv%0d", i), 32'(txv_w[i]), 32'(m_rem[i] > 0));
                if (m_dk[i]) chk($sformatf("model_dout%0d", i), 32'(dout_w[i]), 32'(m_dout[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cmd(input logic [9:0] w);
        din = w; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; din = 10'h000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Counts cycles with tx_valid high on instance i over a 12-cycle window.
    task automatic count_hold(input int i, output int n);
        n = 0;
        repeat (12) begin
            if (txv_w[i]) n++;
            @(posedge clk); #1;
        end
    endtask

    int n_hold;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; din = 10'h000;
        idle(2);
        run = 1'b1;
        chk("rst_dout", 32'(dout_a), 32'h00);
        chk("rst_txv", 32'(txv_a), 32'h0);
        rst_n = 1'b1;
        idle(10);
        chk("idle_dout", 32'(dout_a), 32'h00);
        chk("idle_txv", 32'(txv_a), 32'h0);

        // Basic write/read.
        cmd(10'h00A); cmd(10'h1A5); cmd(10'h20A); cmd(10'h300);
        chk("rd_a5_dout", 32'(dout_a), 32'hA5);
        chk("rd_a5_txv", 32'(txv_a), 32'h1);
        count_hold(0, n_hold);
        chk("hold_len", 32'(n_hold), 32'd8);
        chk("after_hold_dout", 32'(dout_a), 32'hA5);

        // Out of range on the 200-deep instance, in range on the 256-deep one.
        cmd(10'h0F0); cmd(10'h133); cmd(10'h2F0); cmd(10'h300);
        chk("oor_dout", 32'(dout_b), 32'h00);
        chk("oor_txv", 32'(txv_b), 32'h1);
        chk("inr_dout", 32'(dout_a), 32'h33);
        cmd(10'h0C7); cmd(10'h15A); cmd(10'h2C7); cmd(10'h300);
        chk("edge199_dout", 32'(dout_b), 32'h5A);
        idle(10);

        // Read restart during hold.
        cmd(10'h001); cmd(10'h111); cmd(10'h002); cmd(10'h122);
        cmd(10'h201); cmd(10'h300);
        chk("rd1_dout", 32'(dout_a), 32'h11);
        idle(2);
        cmd(10'h202); cmd(10'h300);
        chk("rd2_dout", 32'(dout_a), 32'h22);
        count_hold(0, n_hold);
        chk("restart_hold_len", 32'(n_hold), 32'd8);

        // Reset on the 4th hold cycle; RAM survives.
        cmd(10'h201); cmd(10'h300);
        idle(3);
        rst_n = 1'b0;
        idle(1);
        chk("midhold_rst_txv", 32'(txv_a), 32'h0);
        chk("midhold_rst_dout", 32'(dout_a), 32'h00);
        rst_n = 1'b1;
        cmd(10'h201); cmd(10'h300);
        chk("post_rst_readback", 32'(dout_a), 32'h11);
        idle(10);

`ifdef AUTO_INC_EN
        cmd(10'h0FF); cmd(10'h111); cmd(10'h122);
        cmd(10'h2FF); cmd(10'h300);
        chk("autoinc_rd0", 32'(dout_a), 32'h11);
        cmd(10'h300);
        chk("autoinc_rd1", 32'(dout_a), 32'h22);
        chk("autoinc_b_rd1", 32'(dout_b), 32'h22);
        idle(10);
`endif

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
